// File: rtl/io_host_driver.sv
// io_host_driver
//   Hardware initiator for the byte handshake between the host side and the
//   AES I/O responder. It sends a 128-bit message and a 128-bit key one byte
//   at a time, triggers AES, then reads the 16 result bytes back.
//   Byte 0 of every 128-bit word is bits [127:120].
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   start                 one-cycle pulse, accepted only when idle
//   msg_in, key_in        message and key, captured when start is accepted
//   to_hw_sig/to_hw_port  control code and data byte driven to the responder
//   to_sw_sig/to_sw_port  control code and data byte from the responder
//   msg_out               result bytes gathered during readback
//   busy                  transaction in flight
//   done                  one-cycle pulse when msg_out is complete
//   error                 sticky abort flag (timeout or responder reset)
//
// State     | meaning
// ----------|------------------------------------------------------------
// IDLE      | waiting for start
// SYNC      | hold sig 0 until the responder reports idle
// MSG_REQ   | present message byte, sig 1, wait for responder sig 1
// MSG_ACK   | sig 2, wait for responder sig 0
// GAP1      | sig 0 gap before key phase
// KEY_REQ   | present key byte, sig 2, wait for responder sig 1
// KEY_ACK   | sig 1, wait for responder sig 0
// GAP2      | sig 0 gap before AES trigger
// AES_REQ   | sig 3, wait for responder sig 2 (result ready)
// GAP3      | sig 0 gap before readback
// RD_REQ    | sig 1, capture responder byte when its sig is 1
// RD_ACK    | sig 2, wait for responder sig 0
// FINISH    | pulse done, return to IDLE

module io_host_driver #(
    parameter int TIMEOUT    = 1024,
    parameter int GAP_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] msg_in,
    input  logic [127:0] key_in,
    output logic [1:0]   to_hw_sig,
    output logic [7:0]   to_hw_port,
    input  logic [1:0]   to_sw_sig,
    input  logic [7:0]   to_sw_port,
    output logic [127:0] msg_out,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam int WD_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int WD_W   = $clog2(WD_MAX + 2);

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_MSG_REQ, S_MSG_ACK, S_GAP1, S_KEY_REQ, S_KEY_ACK,
        S_GAP2, S_AES_REQ, S_GAP3, S_RD_REQ, S_RD_ACK, S_FINISH
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [WD_W-1:0] r_wd;
    logic [127:0]    r_msg;
    logic [127:0]    r_key;
    logic [1:0]      r_to_hw_sig;
    logic [7:0]      r_to_hw_port;
    logic [127:0]    r_msg_out;
    logic            r_busy;
    logic            r_done;
    logic            r_error;

    logic w_wd_expired;
    logic w_resp_rst;
    logic w_gap_done;
    logic w_advance;
    logic w_abort;

    function automatic logic [7:0] byte_sel(input logic [127:0] v, input logic [3:0] idx);
        byte_sel = v[8*(15 - int'(idx)) +: 8];
    endfunction

    // r_wd counts cycles spent in the current state; it doubles as the gap timer.
    assign w_wd_expired = (TIMEOUT != 0) && (int'(r_wd) == TIMEOUT - 1);
    assign w_gap_done   = int'(r_wd) >= GAP_CYCLES - 1;
    assign w_resp_rst   = (to_sw_sig == 2'd3) && (r_state != S_IDLE) && (r_state != S_SYNC);
    // A state that is allowed to move on this edge is never aborted by the watchdog.
    assign w_abort      = w_resp_rst || (!w_advance && w_wd_expired);

    always_comb begin
        w_advance = 1'b0;
        case (r_state)
            S_SYNC:                          w_advance = (to_sw_sig == 2'd0);
            S_MSG_REQ, S_KEY_REQ, S_RD_REQ:  w_advance = (to_sw_sig == 2'd1);
            S_MSG_ACK, S_KEY_ACK, S_RD_ACK:  w_advance = (to_sw_sig == 2'd0);
            S_GAP1, S_GAP2, S_GAP3:          w_advance = w_gap_done && (to_sw_sig == 2'd0);
            S_AES_REQ:                       w_advance = (to_sw_sig == 2'd2);
            S_FINISH:                        w_advance = 1'b1;
            default:                         w_advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wd         <= '0;
            r_msg        <= '0;
            r_key        <= '0;
            r_to_hw_sig  <= '0;
            r_to_hw_port <= '0;
            r_msg_out    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                r_wd <= '0;
                if (start) begin
                    r_msg       <= msg_in;
                    r_key       <= key_in;
                    r_error     <= 1'b0;
                    r_busy      <= 1'b1;
                    r_cnt       <= '0;
                    r_to_hw_sig <= 2'd0;
                    r_state     <= S_SYNC;
                end
            end else if (w_abort) begin
                r_state      <= S_IDLE;
                r_error      <= 1'b1;
                r_busy       <= 1'b0;
                r_to_hw_sig  <= 2'd0;
                r_to_hw_port <= 8'd0;
                r_cnt        <= '0;
                r_wd         <= '0;
            end else if (w_advance) begin
                r_wd <= '0;
                case (r_state)
                    S_SYNC: begin
                        r_cnt        <= '0;
                        r_to_hw_sig  <= 2'd1;
                        r_to_hw_port <= byte_sel(r_msg, 4'd0);
                        r_state      <= S_MSG_REQ;
                    end
                    S_MSG_REQ: begin
                        r_to_hw_sig <= 2'd2;
                        r_state     <= S_MSG_ACK;
                    end
                    S_MSG_ACK: begin
                        if (r_cnt == 4'd15) begin
                            r_cnt       <= '0;
                            r_to_hw_sig <= 2'd0;
                            r_state     <= S_GAP1;
                        end else begin
                            r_cnt        <= r_cnt + 4'd1;
                            r_to_hw_sig  <= 2'd1;
                            r_to_hw_port <= byte_sel(r_msg, r_cnt + 4'd1);
                            r_state      <= S_MSG_REQ;
                        end
                    end
                    S_GAP1: begin
                        r_to_hw_sig  <= 2'd2;
                        r_to_hw_port <= byte_sel(r_key, 4'd0);
                        r_state      <= S_KEY_REQ;
                    end
                    S_KEY_REQ: begin
                        r_to_hw_sig <= 2'd1;
                        r_state     <= S_KEY_ACK;
                    end
                    S_KEY_ACK: begin
                        if (r_cnt == 4'd15) begin
                            r_cnt       <= '0;
                            r_to_hw_sig <= 2'd0;
                            r_state     <= S_GAP2;
                        end else begin
                            r_cnt        <= r_cnt + 4'd1;
                            r_to_hw_sig  <= 2'd2;
                            r_to_hw_port <= byte_sel(r_key, r_cnt + 4'd1);
                            r_state      <= S_KEY_REQ;
                        end
                    end
                    S_GAP2: begin
                        r_to_hw_sig <= 2'd3;
                        r_state     <= S_AES_REQ;
                    end
                    S_AES_REQ: begin
                        r_to_hw_sig <= 2'd0;
                        r_state     <= S_GAP3;
                    end
                    S_GAP3: begin
                        r_to_hw_sig <= 2'd1;
                        r_state     <= S_RD_REQ;
                    end
                    S_RD_REQ: begin
                        r_msg_out[8*(15 - int'(r_cnt)) +: 8] <= to_sw_port;
                        r_to_hw_sig <= 2'd2;
                        r_state     <= S_RD_ACK;
                    end
                    S_RD_ACK: begin
                        if (r_cnt == 4'd15) begin
                            r_cnt       <= '0;
                            r_to_hw_sig <= 2'd0;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_FINISH;
                        end else begin
                            r_cnt       <= r_cnt + 4'd1;
                            r_to_hw_sig <= 2'd1;
                            r_state     <= S_RD_REQ;
                        end
                    end
                    S_FINISH: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (r_wd != {WD_W{1'b1}}) begin
                r_wd <= r_wd + WD_W'(1);
            end
        end
    end

    assign to_hw_sig  = r_to_hw_sig;
    assign to_hw_port = r_to_hw_port;
    assign msg_out    = r_msg_out;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_io_host_driver.sv
// Testbench for io_host_driver: a behavioural responder answers the byte
// handshake, records what it receives and returns message XOR key.
module tb_io_host_driver;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [127:0] msg_in;
    logic [127:0] key_in;
    logic [1:0]   to_hw_sig;
    logic [7:0]   to_hw_port;
    logic [1:0]   to_sw_sig;
    logic [7:0]   to_sw_port;
    logic [127:0] msg_out;
    logic         busy;
    logic         done;
    logic         error;

    int n_tests   = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int stab_err  = 0;
    int to_cycles = 0;
    bit hold_active = 1'b0;
    logic [7:0]   hold_val = 8'd0;
    logic [127:0] rx_msg;
    logic [127:0] rx_key;

    localparam int M_NORMAL = 0, M_KEY_RST = 1, M_AES_TO = 2, M_RESTART = 3, M_RD_RESET = 4;

    always #5 clk = ~clk;

    io_host_driver #(.TIMEOUT(50), .GAP_CYCLES(2)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .msg_in     (msg_in),
        .key_in     (key_in),
        .to_hw_sig  (to_hw_sig),
        .to_hw_port (to_hw_port),
        .to_sw_sig  (to_sw_sig),
        .to_sw_port (to_sw_port),
        .msg_out    (msg_out),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (hold_active && (to_hw_port !== hold_val)) stab_err++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got hang required finish");
        $fatal(1, "global timeout");
    end

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
        return v[8*(15 - i) +: 8];
    endfunction

    task automatic stall(input int max_stall);
        int d;
        d = $urandom_range(max_stall, 0);
        repeat (d) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_hw(input logic [1:0] code, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (to_hw_sig == code) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drop_and_release();
        to_sw_sig = 2'd0;
        @(posedge clk);
        hold_active = 1'b0;
        #1;
    endtask

    // Responder bus model. Returns ok=0 if the host stopped following the protocol.
    task automatic run_responder(input int max_stall, input int mode, output bit ok);
        bit w;
        logic [127:0] res;
        ok = 1'b0;
        rx_msg = '0;
        rx_key = '0;
        for (int i = 0; i < 16; i++) begin
            wait_hw(2'd1, w); if (!w) return;
            hold_val = to_hw_port;
            hold_active = 1'b1;
            rx_msg[8*(15 - i) +: 8] = to_hw_port;
            if (mode == M_RESTART && i == 4) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                msg_in = ~msg_in;
                key_in = ~key_in;
                check_val("busy_on_restart", busy, 1'b1);
            end
            stall(max_stall);
            to_sw_sig = 2'd1;
            wait_hw(2'd2, w); if (!w) return;
            stall(max_stall);
            drop_and_release();
        end
        wait_hw(2'd0, w); if (!w) return;
        for (int i = 0; i < 16; i++) begin
            wait_hw(2'd2, w); if (!w) return;
            hold_val = to_hw_port;
            hold_active = 1'b1;
            rx_key[8*(15 - i) +: 8] = to_hw_port;
            if (mode == M_KEY_RST && i == 7) begin
                to_sw_sig = 2'd3;
                @(posedge clk);
                hold_active = 1'b0;
                #1;
                to_sw_sig = 2'd0;
                ok = 1'b1;
                return;
            end
            stall(max_stall);
            to_sw_sig = 2'd1;
            wait_hw(2'd1, w); if (!w) return;
            stall(max_stall);
            drop_and_release();
        end
        wait_hw(2'd3, w); if (!w) return;
        if (mode == M_AES_TO) begin
            to_cycles = 0;
            for (int k = 1; k <= 200; k++) begin
                @(posedge clk);
                #1;
                if (error) begin
                    to_cycles = k;
                    break;
                end
            end
            ok = 1'b1;
            return;
        end
        stall(max_stall);
        to_sw_sig = 2'd2;
        wait_hw(2'd0, w); if (!w) return;
        stall(max_stall);
        to_sw_sig = 2'd0;
        res = rx_msg ^ rx_key;
        for (int i = 0; i < 16; i++) begin
            wait_hw(2'd1, w); if (!w) return;
            if (mode == M_RD_RESET && i == 5) begin
                #2;
                reset_n = 1'b0;
                #1;
                check_val("rst_msg_out", msg_out, '0);
                check_val("rst_sig_port", {to_hw_sig, to_hw_port}, '0);
                check_val("rst_flags", {busy, done, error}, '0);
                to_sw_sig = 2'd0;
                to_sw_port = 8'd0;
                @(negedge clk);
                reset_n = 1'b1;
                @(posedge clk);
                #1;
                ok = 1'b1;
                return;
            end
            stall(max_stall);
            to_sw_port = byte_of(res, i);
            to_sw_sig = 2'd1;
            wait_hw(2'd2, w); if (!w) return;
            stall(max_stall);
            to_sw_sig = 2'd0;
            @(posedge clk);
            #1;
        end
        ok = 1'b1;
    endtask

    task automatic run_txn(input logic [127:0] m, input logic [127:0] k,
                           input int max_stall, input int mode, output int n_done);
        bit ok;
        int d0;
        d0 = done_cnt;
        msg_in = m;
        key_in = k;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("busy_rise", busy, 1'b1);
        check_val("err_clear", error, 1'b0);
        run_responder(max_stall, mode, ok);
        check_val("resp_protocol", ok, 1'b1);
        if (!ok) begin
            to_sw_sig = 2'd0;
            reset_n = 1'b0;
            #3;
            reset_n = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        n_done = done_cnt - d0;
    endtask

    initial begin
        logic [127:0] m;
        logic [127:0] k;
        int nd;
        reset_n    = 1'b0;
        start      = 1'b0;
        to_sw_sig  = 2'd0;
        to_sw_port = 8'd0;
        msg_in     = '0;
        key_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_msg_out", msg_out, '0);
        check_val("reset_sig_port", {to_hw_sig, to_hw_port}, '0);
        check_val("reset_flags", {busy, done, error}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // nominal transaction
        m = 128'h00112233445566778899AABBCCDDEEFF;
        k = 128'h000102030405060708090A0B0C0D0E0F;
        run_txn(m, k, 0, M_NORMAL, nd);
        check_val("nom_rx_msg", rx_msg, m);
        check_val("nom_rx_key", rx_key, k);
        check_val("nom_msg_out", msg_out, 128'h00102030405060708090A0B0C0D0E0F0);
        check_val("nom_done", nd, 1);
        check_val("nom_idle", {busy, error, to_hw_sig}, '0);

        // random data with handshake stalls
        for (int t = 0; t < 3; t++) begin
            m = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            run_txn(m, k, 7, M_NORMAL, nd);
            check_val("stall_rx_msg", rx_msg, m);
            check_val("stall_rx_key", rx_key, k);
            check_val("stall_msg_out", msg_out, m ^ k);
            check_val("stall_done", nd, 1);
        end

        // AES never answers
        m = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        run_txn(m, k, 3, M_AES_TO, nd);
        check_val("to_cycles", to_cycles, 50);
        check_val("to_error", error, 1'b1);
        check_val("to_sig_busy", {to_hw_sig, busy}, '0);
        check_val("to_no_done", nd, 0);

        // responder reset in key phase, then a clean transaction
        run_txn(m, k, 2, M_KEY_RST, nd);
        check_val("rr_error", error, 1'b1);
        check_val("rr_sig_port_busy", {to_hw_sig, to_hw_port, busy}, '0);
        check_val("rr_no_done", nd, 0);
        m = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        run_txn(m, k, 2, M_NORMAL, nd);
        check_val("rr_after_out", msg_out, m ^ k);
        check_val("rr_after_flags", {error, nd[1:0]}, 3'b001);

        // second start mid-message and input changes after capture
        m = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        run_txn(m, k, 2, M_RESTART, nd);
        check_val("rs_rx_msg", rx_msg, m);
        check_val("rs_rx_key", rx_key, k);
        check_val("rs_msg_out", msg_out, m ^ k);
        check_val("rs_done", nd, 1);

        // asynchronous reset in readback, then recovery
        run_txn(m ^ 128'h5, k, 1, M_RD_RESET, nd);
        check_val("ar_no_done", nd, 0);
        check_val("ar_outputs", {msg_out, to_hw_sig, busy, error}, '0);
        m = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        run_txn(m, k, 4, M_NORMAL, nd);
        check_val("ar_after_out", msg_out, m ^ k);
        check_val("ar_after_done", nd, 1);

        check_val("port_stable", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_host_driver.md
Name: io_host_driver

Overview:
- Hardware initiator for the 2-bit-signal / 8-bit-port byte handshake between software and the AES I/O block.
- Takes a 128-bit message and a 128-bit key and streams each one byte at a time to the responder. It then triggers AES and reads the 16 decrypted bytes back.
- Replaces the Nios II software side in simulation and in standalone builds. Its to_hw_* outputs drive the responder's to_hw_* inputs, and its to_sw_* inputs come from the responder's to_sw_* outputs.

Parameters:
- TIMEOUT, 1024, maximum cycles spent in any single wait state before error; 0 disables the watchdog.
- GAP_CYCLES, 2, cycles to_hw_sig is held at 0 between phases.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a full transaction
- msg_in  in  128  encrypted message; byte 0 = [127:120]
- key_in  in  128  AES key; byte 0 = [127:120]
- to_hw_sig  out  2  host-to-responder control code
- to_hw_port  out  8  host-to-responder data byte
- to_sw_sig  in  2  responder-to-host control code
- to_sw_port  in  8  responder-to-host data byte
- msg_out  out  128  decrypted result; byte 0 = [127:120]
- busy  out  1  high from the cycle after start until done or error
- done  out  1  one-cycle pulse when msg_out is complete
- error  out  1  sticky; set on timeout or responder reset; cleared by the next accepted start

Behaviour:
- Reset (asynchronous, active-low) sets outputs and internal state as follows:
  - to_hw_sig=0, to_hw_port=0, msg_out=0, busy=0, done=0, error=0.
  - State=IDLE, byte counter=0, watchdog=0.
- Start acceptance:
  - start is accepted only in IDLE. On acceptance, msg_in and key_in are captured into shadow registers; later changes to the inputs have no effect.
  - start while busy is ignored.
- States: IDLE, SYNC, MSG_REQ, MSG_ACK, GAP1, KEY_REQ, KEY_ACK, GAP2, AES_REQ, GAP3, RD_REQ, RD_ACK, FINISH.
- SYNC: to_hw_sig=0. Wait for to_sw_sig==0 (responder idle), then go to MSG_REQ with counter=0.
- Byte-send phases use a request code R and an ack code A:
  - Message phase: R=1, A=2. Key phase: R=2, A=1.
  - *_REQ: drive to_hw_sig=R and to_hw_port=shadow byte[counter]. Wait for to_sw_sig==1, then go to *_ACK.
  - *_ACK: drive to_hw_sig=A, port unchanged. Wait for to_sw_sig==0.
  - After an ACK, if counter<15: counter+1 and back to *_REQ. If counter==15: counter=0 and go to the following GAP state.
  - to_hw_port stays stable from entry to REQ until exit from ACK.
- GAPn: drive to_hw_sig=0 for GAP_CYCLES cycles and require to_sw_sig==0 on the last cycle.
  - GAP1 leads to KEY_REQ, GAP2 leads to AES_REQ, GAP3 leads to RD_REQ.
- AES_REQ: drive to_hw_sig=3 and wait for to_sw_sig==2 (result ready), then go to GAP3. AES latency is unbounded except by the watchdog.
- Readback:
  - RD_REQ: drive to_hw_sig=1. When to_sw_sig==1, capture to_sw_port into msg_out byte[counter] on that same edge, then go to RD_ACK.
  - RD_ACK: drive to_hw_sig=2 and wait for to_sw_sig==0.
  - After RD_ACK, if counter<15: counter+1 and back to RD_REQ. If counter==15: go to FINISH.
- FINISH: to_hw_sig=0, done=1 for one cycle, busy falls, go to IDLE.
- msg_out holds its last value until the next readback overwrites it byte by byte. Bytes not yet received keep their old values.
- Watchdog:
  - Counts cycles in the current state and resets on every state change.
  - When it reaches TIMEOUT: error=1, to_hw_sig=0, to_hw_port=0, busy=0, go to IDLE, no done pulse.
- Responder reset detection: to_sw_sig==3 in any state other than IDLE or SYNC gets the same abort as a timeout.
- If to_sw_sig==3 in SYNC, keep waiting.
- Asynchronous reset mid-transaction aborts immediately and leaves all outputs at reset values.

Test Plan:
- Nominal transaction:
  - Stimulus: reset, bus-model responder echoing the message XOR the key; msg_in=0x00112233445566778899AABBCCDDEEFF, key_in=0x000102030405060708090A0B0C0D0E0F; start.
  - Required: the responder receives 16 message bytes then 16 key bytes in order from byte 0 ([127:120]).
  - Required: msg_out=0x00102030405060708090A0B0C0D0E0F0, one done pulse, error=0.
- Handshake stall: responder delays each to_sw_sig transition by 0–7 random cycles.
  - Required: to_hw_port never changes between REQ entry and ACK exit, and the final msg_out matches.
- AES timeout: TIMEOUT=50; responder never returns 2 in AES_REQ.
  - Required: error=1 exactly 50 cycles after AES_REQ entry, to_hw_sig=0, busy=0, no done.
- Responder reset: force to_sw_sig=3 during the key phase at byte 7.
  - Required: abort to IDLE with error=1. A following start clears error and completes normally.
- Start while busy / input hold: pulse start again mid-message and change msg_in after the first start.
  - Required: the second start is ignored and the transmitted bytes equal the originally captured values.
- Asynchronous reset mid-readback: assert reset_n=0 at readback byte 5.
  - Required: all outputs are 0 in the same cycle, and the state returns to IDLE.
